// File: rtl/secure_reg_pkg.sv
// Shared types and constants for the secure register request front-end.
package secure_reg_pkg;

    // Controller states:
    //   ST_IDLE    - ready for a new request
    //   ST_ISSUE   - single register strobe cycle
    //   ST_CAPTURE - sample register read data
    //   ST_RESP    - response held until accepted
    //   ST_LOCKED  - requests blocked after repeated denials
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_RESP    = 3'd3,
        ST_LOCKED  = 3'd4
    } state_e;

    // Response error codes carried on rsp_err.
    localparam logic RSP_OK     = 1'b0;
    localparam logic RSP_DENIED = 1'b1;

    // Thread id allowed to reach the register unless overridden.
    localparam int DEFAULT_PRIV_TID = 0;

endpackage

// File: rtl/secure_lockout_timer.sv
// Lockout down-counter: loaded with the lockout length, decremented while
// locked, flags the cycle on which it reaches zero.
module secure_lockout_timer #(
    parameter int LOCKOUT_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    input  logic dec_i,
    output logic done_o
);

    localparam int            CW       = $clog2(LOCKOUT_CYCLES + 1);
    localparam logic [CW-1:0] LOAD_VAL = CW'(LOCKOUT_CYCLES);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Next count: load has priority, decrement stops at zero.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = LOAD_VAL;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // The decrement taking the count from one to zero ends the lockout.
    assign done_o = dec_i && (count_q <= CW'(1));

endmodule

// File: rtl/secure_reg_access_ctrl.sv
// Request front-end for the thread-gated secure register.
// Only the privileged thread gets a register strobe; other threads get an
// error response, and a run of denials locks the interface for a while.
//
//   state      | meaning
//   -----------+-----------------------------------------------------
//   ST_IDLE    | req_ready high, waiting for a request
//   ST_ISSUE   | one-cycle reg_access_en (and reg_wr_en for writes)
//   ST_CAPTURE | register read data sampled into the response
//   ST_RESP    | rsp_valid high, fields held until rsp_ready
//   ST_LOCKED  | requests blocked until the lockout timer expires
module secure_reg_access_ctrl
    import secure_reg_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int TID_WIDTH      = 2,
    parameter int PRIV_TID       = DEFAULT_PRIV_TID,
    parameter int LOCKOUT_THRESH = 4,
    parameter int LOCKOUT_CYCLES = 16
) (
    input  logic                                    clk_i,
    input  logic                                    rst_i,
    input  logic                                    req_valid_i,
    output logic                                    req_ready_o,
    input  logic [TID_WIDTH-1:0]                    req_tid_i,
    input  logic                                    req_write_i,
    input  logic [DATA_WIDTH-1:0]                   req_wdata_i,
    output logic                                    reg_access_en_o,
    output logic                                    reg_wr_en_o,
    output logic [DATA_WIDTH-1:0]                   reg_data_in_o,
    input  logic [DATA_WIDTH-1:0]                   reg_data_out_i,
    output logic                                    rsp_valid_o,
    input  logic                                    rsp_ready_i,
    output logic [TID_WIDTH-1:0]                    rsp_tid_o,
    output logic [DATA_WIDTH-1:0]                   rsp_rdata_o,
    output logic                                    rsp_err_o,
    output logic                                    locked_o,
    output logic [$clog2(LOCKOUT_THRESH+1)-1:0]     deny_count_o
);

    localparam int             DCW      = $clog2(LOCKOUT_THRESH + 1);
    localparam logic [DCW-1:0] THRESH_C = DCW'(LOCKOUT_THRESH);
    localparam logic [TID_WIDTH-1:0] PRIV_TID_C = TID_WIDTH'(PRIV_TID);

    state_e                  state_q;
    logic                    req_ready_q;
    logic [TID_WIDTH-1:0]    req_tid_q;
    logic                    req_write_q;
    logic                    reg_access_en_q;
    logic                    reg_wr_en_q;
    logic [DATA_WIDTH-1:0]   reg_data_in_q;
    logic                    rsp_valid_q;
    logic [TID_WIDTH-1:0]    rsp_tid_q;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q;
    logic                    rsp_err_q;
    logic                    locked_q;
    logic [DCW-1:0]          deny_count_q;

    logic tmr_load;
    logic tmr_dec;
    logic tmr_done;

    // Lockout starts on the response handshake that completes the denial run.
    assign tmr_load = (state_q == ST_RESP) && rsp_ready_i && (deny_count_q == THRESH_C);
    assign tmr_dec  = (state_q == ST_LOCKED);

    secure_lockout_timer #(
        .LOCKOUT_CYCLES (LOCKOUT_CYCLES)
    ) u_lockout_timer (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .load_i (tmr_load),
        .dec_i  (tmr_dec),
        .done_o (tmr_done)
    );

    // Controller FSM with all outputs registered. Strobes default low every
    // cycle so they can only ever last the single ISSUE cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q         <= ST_IDLE;
            req_ready_q     <= 1'b0;
            req_tid_q       <= '0;
            req_write_q     <= 1'b0;
            reg_access_en_q <= 1'b0;
            reg_wr_en_q     <= 1'b0;
            reg_data_in_q   <= '0;
            rsp_valid_q     <= 1'b0;
            rsp_tid_q       <= '0;
            rsp_rdata_q     <= '0;
            rsp_err_q       <= RSP_OK;
            locked_q        <= 1'b0;
            deny_count_q    <= '0;
        end else begin
            reg_access_en_q <= 1'b0;
            reg_wr_en_q     <= 1'b0;
            reg_data_in_q   <= '0;

            case (state_q)
                ST_IDLE: begin
                    req_ready_q <= 1'b1;
                    if (req_ready_q && req_valid_i) begin
                        req_ready_q <= 1'b0;
                        req_tid_q   <= req_tid_i;
                        req_write_q <= req_write_i;
                        if (req_tid_i == PRIV_TID_C) begin
                            state_q         <= ST_ISSUE;
                            reg_access_en_q <= 1'b1;
                            reg_wr_en_q     <= req_write_i;
                            reg_data_in_q   <= req_wdata_i;
                        end else begin
                            state_q     <= ST_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_tid_q   <= req_tid_i;
                            rsp_rdata_q <= '0;
                            rsp_err_q   <= RSP_DENIED;
                            if (deny_count_q < THRESH_C) begin
                                deny_count_q <= deny_count_q + DCW'(1);
                            end
                        end
                    end
                end

                ST_ISSUE: begin
                    state_q <= ST_CAPTURE;
                end

                ST_CAPTURE: begin
                    state_q      <= ST_RESP;
                    rsp_valid_q  <= 1'b1;
                    rsp_tid_q    <= req_tid_q;
                    rsp_rdata_q  <= req_write_q ? '0 : reg_data_out_i;
                    rsp_err_q    <= RSP_OK;
                    deny_count_q <= '0;
                end

                ST_RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        if (deny_count_q == THRESH_C) begin
                            state_q  <= ST_LOCKED;
                            locked_q <= 1'b1;
                        end else begin
                            state_q     <= ST_IDLE;
                            req_ready_q <= 1'b1;
                        end
                    end
                end

                ST_LOCKED: begin
                    if (tmr_done) begin
                        state_q      <= ST_IDLE;
                        req_ready_q  <= 1'b1;
                        locked_q     <= 1'b0;
                        deny_count_q <= '0;
                    end
                end

                default: begin
                    state_q     <= ST_IDLE;
                    req_ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready_o     = req_ready_q;
    assign reg_access_en_o = reg_access_en_q;
    assign reg_wr_en_o     = reg_wr_en_q;
    assign reg_data_in_o   = reg_data_in_q;
    assign rsp_valid_o     = rsp_valid_q;
    assign rsp_tid_o       = rsp_tid_q;
    assign rsp_rdata_o     = rsp_rdata_q;
    assign rsp_err_o       = rsp_err_q;
    assign locked_o        = locked_q;
    assign deny_count_o    = deny_count_q;

endmodule

// File: tb/tb_secure_reg_access_ctrl.sv
// Bench for secure_reg_access_ctrl: directed steps then random transactions,
// checked against a transaction-level model of grants, denials and lockout.
module tb_secure_reg_access_ctrl;

    localparam int THRESH = 4;
    localparam int LOCK_CYC = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_tid = '0;
    logic        req_write = 1'b0;
    logic [31:0] req_wdata = '0;
    logic        reg_access_en;
    logic        reg_wr_en;
    logic [31:0] reg_data_in;
    logic [31:0] reg_data_out = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [1:0]  rsp_tid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        locked;
    logic [2:0]  deny_count;

    int          checks = 0;
    int          errors = 0;
    int          m_deny = 0;
    logic [31:0] m_reg  = '0;
    logic [31:0] stub_q = '0;

    secure_reg_access_ctrl dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .req_valid_i     (req_valid),
        .req_ready_o     (req_ready),
        .req_tid_i       (req_tid),
        .req_write_i     (req_write),
        .req_wdata_i     (req_wdata),
        .reg_access_en_o (reg_access_en),
        .reg_wr_en_o     (reg_wr_en),
        .reg_data_in_o   (reg_data_in),
        .reg_data_out_i  (reg_data_out),
        .rsp_valid_o     (rsp_valid),
        .rsp_ready_i     (rsp_ready),
        .rsp_tid_o       (rsp_tid),
        .rsp_rdata_o     (rsp_rdata),
        .rsp_err_o       (rsp_err),
        .locked_o        (locked),
        .deny_count_o    (deny_count)
    );

    always #5 clk = ~clk;

    // Register stub: read data valid only in the cycle after a read strobe.
    always @(posedge clk) begin
        if (reg_access_en && reg_wr_en) stub_q <= reg_data_in;
        if (reg_access_en && !reg_wr_en) reg_data_out <= stub_q;
        else reg_data_out <= $urandom;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (req_ready !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk("ready_wait", req_ready, 1);
    endtask

    task automatic chk_reset_vals();
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_tid", rsp_tid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_access_en", reg_access_en, 0);
        chk("rst_wr_en", reg_wr_en, 0);
        chk("rst_data_in", reg_data_in, 0);
        chk("rst_locked", locked, 0);
        chk("rst_deny", deny_count, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        tick();
        tick();
        chk_reset_vals();
        rst = 1'b0;
        tick();
        chk("post_rst_ready", req_ready, 1);
        m_deny = 0;
    endtask

    // One complete transaction with model prediction and lockout follow-up.
    task automatic do_req(input logic [1:0] tid, input logic wr, input logic [31:0] wdata,
                          input int hold, input int pre_idle);
        bit          grant;
        bit          lock_exp;
        int          lat;
        int          k;
        int          n;
        logic [31:0] exp_rd;
        logic        exp_err;

        for (int i = 0; i < pre_idle; i++) begin
            req_valid = 1'b0;
            tick();
        end
        wait_ready();
        req_valid = 1'b1;
        req_tid   = tid;
        req_write = wr;
        req_wdata = wdata;
        tick();
        req_valid = 1'b0;
        req_tid   = 2'($urandom);
        req_write = 1'($urandom);
        req_wdata = $urandom;
        rsp_ready = 1'($urandom_range(0, 1));

        grant = (tid == 2'd0);
        if (grant) begin
            exp_rd  = wr ? 32'h0 : m_reg;
            exp_err = 1'b0;
            lat     = 3;
            if (wr) m_reg = wdata;
            m_deny  = 0;
        end else begin
            exp_rd  = 32'h0;
            exp_err = 1'b1;
            lat     = 1;
            if (m_deny < THRESH) m_deny++;
        end
        lock_exp = !grant && (m_deny == THRESH);

        k = 1;
        while (rsp_valid !== 1'b1 && k < 8) begin
            chk("strobe_en", reg_access_en, grant && k == 1);
            chk("strobe_wr", reg_wr_en, grant && k == 1 && wr);
            chk("strobe_data", reg_data_in, (grant && k == 1) ? wdata : 32'h0);
            chk("busy_ready", req_ready, 0);
            rsp_ready = 1'($urandom_range(0, 1));
            tick();
            k++;
        end
        chk("rsp_latency", k, lat);
        chk("resp_no_strobe", reg_access_en, 0);
        chk("resp_data_in", reg_data_in, 0);
        chk("rsp_tid", rsp_tid, tid);
        chk("rsp_rdata", rsp_rdata, exp_rd);
        chk("rsp_err", rsp_err, exp_err);
        chk("deny_count", deny_count, m_deny);
        chk("resp_locked", locked, 0);

        for (int h = 0; h < hold; h++) begin
            rsp_ready = 1'b0;
            tick();
            chk("hold_valid", rsp_valid, 1);
            chk("hold_tid", rsp_tid, tid);
            chk("hold_rdata", rsp_rdata, exp_rd);
            chk("hold_err", rsp_err, exp_err);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'($urandom_range(0, 1));
        chk("rsp_drop", rsp_valid, 0);

        if (lock_exp) begin
            n = 0;
            req_valid = 1'b1;
            req_tid   = 2'd0;
            req_write = 1'b0;
            while (req_ready !== 1'b1 && n < 40) begin
                chk("lock_flag", locked, 1);
                chk("lock_no_strobe", reg_access_en, 0);
                tick();
                n++;
            end
            req_valid = 1'b0;
            chk("lock_len", n, LOCK_CYC);
            chk("unlock_flag", locked, 0);
            chk("unlock_deny", deny_count, 0);
            m_deny = 0;
        end else begin
            chk("ready_back", req_ready, 1);
            chk("not_locked", locked, 0);
        end
    endtask

    initial begin
        // Reset values
        do_reset();

        // Privileged write, then read it back
        do_req(2'd0, 1'b1, 32'hDEADBEEF, 0, 0);
        do_req(2'd0, 1'b0, 32'h0, 0, 0);

        // Unprivileged write is denied
        do_req(2'd2, 1'b1, 32'h12345678, 0, 1);

        // Clear the denial run, then four denials trigger lockout
        do_req(2'd0, 1'b0, 32'h0, 0, 0);
        for (int i = 0; i < 4; i++) do_req(2'd1, 1'b0, $urandom, 0, 0);
        do_req(2'd0, 1'b0, 32'h0, 0, 0);

        // Backpressure and denial run broken by a privileged access
        do_req(2'd1, 1'b0, 32'h0, 5, 0);
        do_req(2'd2, 1'b1, 32'hA5A5A5A5, 0, 0);
        do_req(2'd3, 1'b0, 32'h0, 2, 1);
        do_req(2'd0, 1'b0, 32'h0, 5, 0);

        // Reset while a request is being accepted: no strobe may appear
        wait_ready();
        req_valid = 1'b1; req_tid = 2'd0; req_write = 1'b1; req_wdata = 32'h0BADF00D;
        rst = 1'b1;
        tick();
        req_valid = 1'b0;
        chk_reset_vals();
        rst = 1'b0;
        tick();
        m_deny = 0;

        // Reset during ISSUE
        wait_ready();
        req_valid = 1'b1; req_tid = 2'd0; req_write = 1'b0;
        tick();
        req_valid = 1'b0;
        chk("issue_strobe", reg_access_en, 1);
        rst = 1'b1;
        tick();
        chk_reset_vals();
        rst = 1'b0;
        tick();
        m_deny = 0;

        // Reset during RESP
        do_req(2'd2, 1'b0, 32'h0, 0, 0);
        wait_ready();
        req_valid = 1'b1; req_tid = 2'd3; req_write = 1'b0;
        tick();
        req_valid = 1'b0;
        chk("resp_before_rst", rsp_valid, 1);
        rst = 1'b1;
        rsp_ready = 1'b0;
        tick();
        chk_reset_vals();
        rst = 1'b0;
        tick();
        m_deny = 0;
        do_req(2'd3, 1'b0, 32'h0, 0, 0);
        do_req(2'd0, 1'b0, 32'h0, 0, 0);

        // Random traffic
        for (int t = 0; t < 80; t++) begin
            logic [1:0] r_tid;
            r_tid = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
            do_req(r_tid, 1'($urandom_range(0, 1)), $urandom,
                   $urandom_range(0, 3), $urandom_range(0, 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
